// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;

  localparam logic [REG_FILE_ADDR_LEN-1:0] R0_ADDR = '0;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic [WORD_LEN-1:0]          val;
    logic                         valid;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback sources and register-file write port bundled for the arbiter.
// master drives the requests and observes the port; slave is the arbiter.
interface regfile_write_arbiter_if;
  import regfile_arb_pkg::*;

  logic                         wb_en;
  logic [REG_FILE_ADDR_LEN-1:0] wb_dest;
  logic [WORD_LEN-1:0]          wb_val;
  logic                         mc_valid;
  logic                         mc_ready;
  logic [REG_FILE_ADDR_LEN-1:0] mc_dest;
  logic [WORD_LEN-1:0]          mc_val;
  logic                         writeEn;
  logic [REG_FILE_ADDR_LEN-1:0] dest;
  logic [WORD_LEN-1:0]          writeVal;
  logic                         stall_pipe;
  logic                         mc_pending;

  modport master (
    output wb_en, wb_dest, wb_val, mc_valid, mc_dest, mc_val,
    input  mc_ready, writeEn, dest, writeVal, stall_pipe, mc_pending
  );

  modport slave (
    input  wb_en, wb_dest, wb_val, mc_valid, mc_dest, mc_val,
    output mc_ready, writeEn, dest, writeVal, stall_pipe, mc_pending
  );

endinterface

// File: rtl/regfile_arb_fifo.sv
// Circular buffer for multi-cycle results. Entries can be invalidated in place
// by destination; invalid entries keep their slot until popped.
module regfile_arb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  wr_req_t                      push_data_i,
  input  logic                         pop_i,
  input  logic                         kill_en_i,
  input  logic [REG_FILE_ADDR_LEN-1:0] kill_dest_i,
  output logic                         full_o,
  output logic                         empty_o,
  output wr_req_t                      head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t       mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Squash matching entries first so a same-cycle push is never squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && mem_q[i].valid && (mem_q[i].dest == kill_dest_i))
          mem_q[i].valid <= 1'b0;
      end
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback always wins, buffered
// multi-cycle results use the free slots. Build macro REGFILE_ARB_STARVE_EN
// adds a one-cycle pipeline stall after too many WB-owned cycles.
//
// state | meaning
// RUN   | WB has priority; starve_cnt counts WB grants while the FIFO waits
// DRAIN | stall_pipe high for one cycle; FIFO head owns the write port
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
`ifdef REGFILE_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  logic    fifo_push, fifo_full, fifo_empty;
  logic    wb_grant, fifo_grant, stall;
  wr_req_t head, push_req, wr_d, wr_q;

  assign bus.mc_ready   = !fifo_full;
  assign bus.mc_pending = !fifo_empty;
  assign bus.stall_pipe = stall;
  assign bus.writeEn    = wr_q.valid;
  assign bus.dest       = wr_q.dest;
  assign bus.writeVal   = wr_q.val;

  // R0 results are accepted but dropped here; R0 WB requests never grant.
  assign fifo_push  = bus.mc_valid && !fifo_full && (bus.mc_dest != R0_ADDR);
  assign push_req   = '{dest: bus.mc_dest, val: bus.mc_val, valid: 1'b1};
  assign wb_grant   = bus.wb_en && (bus.wb_dest != R0_ADDR) && !stall;
  assign fifo_grant = !wb_grant && !fifo_empty;

  regfile_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_grant),
    .kill_en_i   (wb_grant),
    .kill_dest_i (bus.wb_dest),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Select the write for next cycle; a squashed head pops with no write.
  always_comb begin
    wr_d = '0;
    if (wb_grant)
      wr_d = '{dest: bus.wb_dest, val: bus.wb_val, valid: 1'b1};
    else if (fifo_grant && head.valid)
      wr_d = head;
  end

  // Register-file port outputs.
  always_ff @(posedge clk) begin
    if (rst) wr_q <= '0;
    else     wr_q <= wr_d;
  end

`ifdef REGFILE_ARB_STARVE_EN
  localparam int CW = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;

  assign stall = (state_q == DRAIN);

  // Next state: count starved cycles, enter DRAIN on the one past the limit.
  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    case (state_q)
      RUN: begin
        if (wb_grant && !fifo_empty) begin
          if (starve_q == CW'(STARVE_LIMIT - 1)) state_d = DRAIN;
          else                                   starve_d = starve_q + 1'b1;
        end
      end
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] val;
    bit          valid;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();
  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // reference model: expected port outputs for the next cycle plus buffer
  ent_t        q[$];
  bit          m_we, m_stall;
  logic [4:0]  m_dest;
  logic [31:0] m_val;
`ifdef REGFILE_ARB_STARVE_EN
  int          starve;
`endif

  int stall_off, r9_off, post_dest;
  bit cur_we;
  logic [4:0] cur_wd;
  logic [31:0] cur_wv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r);
    bit wbg, ns;
    int sz;
    ent_t h;
    if (r) begin
      m_we = 0; m_dest = '0; m_val = '0; m_stall = 0;
      q.delete();
`ifdef REGFILE_ARB_STARVE_EN
      starve = 0;
`endif
      return;
    end
    sz  = q.size();
    wbg = bus.wb_en && (bus.wb_dest != 0) && !m_stall;
    m_we = 0; m_dest = '0; m_val = '0;
    if (wbg) begin
      m_we = 1; m_dest = bus.wb_dest; m_val = bus.wb_val;
    end else if (sz > 0) begin
      h = q.pop_front();
      if (h.valid) begin m_we = 1; m_dest = h.dest; m_val = h.val; end
    end
    ns = 0;
`ifdef REGFILE_ARB_STARVE_EN
    if (wbg && sz > 0) begin
      if (starve == LIMIT - 1) begin ns = 1; starve = 0; end
      else starve++;
    end else starve = 0;
`endif
    if (wbg) foreach (q[i]) if (q[i].dest == bus.wb_dest) q[i].valid = 0;
    if (bus.mc_valid && sz < DEPTH && bus.mc_dest != 0)
      q.push_back('{dest: bus.mc_dest, val: bus.mc_val, valid: 1'b1});
    m_stall = ns;
  endtask

  task automatic cyc(input bit r, input bit we, input logic [4:0] wd, input logic [31:0] wv,
                     input bit mv, input logic [4:0] md, input logic [31:0] mval);
    rst = r;
    bus.wb_en = we; bus.wb_dest = wd; bus.wb_val = wv;
    bus.mc_valid = mv; bus.mc_dest = md; bus.mc_val = mval;
    model_step(r);
    @(posedge clk);
    #1;
    check("writeEn", bus.writeEn, m_we);
    check("dest", bus.dest, m_dest);
    check("writeVal", bus.writeVal, m_val);
    check("stall_pipe", bus.stall_pipe, m_stall);
    check("mc_ready", bus.mc_ready, q.size() < DEPTH);
    check("mc_pending", bus.mc_pending, q.size() != 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_we", bus.writeEn, 0);
    check("rst_stall", bus.stall_pipe, 0);
    check("rst_ready", bus.mc_ready, 1);
    check("rst_pending", bus.mc_pending, 0);

    // WB only
    cyc(0, 1, 3, 32'hA5, 0, 0, 0);
    check("wb_we", bus.writeEn, 1);
    check("wb_dest", bus.dest, 3);
    check("wb_val", bus.writeVal, 32'hA5);
    cyc(0, 1, 0, 32'h55, 0, 0, 0);
    check("wb_r0_we", bus.writeEn, 0);

    // MC only: enqueue, head granted next cycle, write visible after that
    cyc(0, 0, 0, 0, 1, 7, 32'h11);
    check("mc_lat1_we", bus.writeEn, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("mc_we", bus.writeEn, 1);
    check("mc_dest", bus.dest, 7);
    check("mc_val", bus.writeVal, 32'h11);

    // fill FIFO behind a busy WB
    cyc(0, 1, 1, 32'h1, 1, 10, 32'h20);
    cyc(0, 1, 1, 32'h1, 1, 11, 32'h21);
    check("full_ready", bus.mc_ready, 0);
    cyc(0, 1, 1, 32'h1, 1, 12, 32'h22);
    check("full_ready_held", bus.mc_ready, 0);
    cyc(0, 0, 0, 0, 1, 12, 32'h22);
    check("ready_after_pop", bus.mc_ready, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    check("drained", bus.mc_pending, 0);

    // collision: WB owns R5 every cycle while R9 waits
    stall_off = -1; r9_off = -1; post_dest = -1;
    cyc(0, 1, 5, 32'h55, 1, 9, 32'h99);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 5, 32'h55, 0, 0, 0);
      if (bus.stall_pipe && stall_off < 0) stall_off = i + 1;
      if (bus.writeEn && bus.dest == 9 && r9_off < 0) r9_off = i + 1;
      if (i + 1 == LIMIT + 3) post_dest = int'(bus.dest);
    end
`ifdef REGFILE_ARB_STARVE_EN
    check("coll_stall_cyc", stall_off, LIMIT + 1);
    check("coll_r9_cyc", r9_off, LIMIT + 2);
    check("coll_wb_resume", post_dest, 5);
`else
    check("coll_no_stall", stall_off, -1);
    check("coll_no_r9", r9_off, -1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("coll_r9_late", bus.dest, 9);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0);

    // squash
    cyc(0, 1, 6, 32'h66, 1, 4, 32'h1);
    cyc(0, 1, 4, 32'h2, 0, 0, 0);
    check("sq_dest", bus.dest, 4);
    check("sq_val", bus.writeVal, 32'h2);
    check("sq_pending", bus.mc_pending, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("sq_nowrite", bus.writeEn, 0);
    check("sq_empty", bus.mc_pending, 0);

    // reset with two buffered entries (in DRAIN when the feature is built)
    cyc(0, 1, 1, 32'h1, 1, 10, 32'hA);
    cyc(0, 1, 1, 32'h1, 1, 11, 32'hB);
`ifdef REGFILE_ARB_STARVE_EN
    for (int i = 0; i < 8 && !m_stall; i++) cyc(0, 1, 1, 32'h1, 0, 0, 0);
    check("drain_state", bus.stall_pipe, 1);
`endif
    cyc(1, 1, 1, 32'h1, 0, 0, 0);
    check("rstd_we", bus.writeEn, 0);
    check("rstd_dest", bus.dest, 0);
    check("rstd_val", bus.writeVal, 0);
    check("rstd_stall", bus.stall_pipe, 0);
    check("rstd_ready", bus.mc_ready, 1);
    check("rstd_pending", bus.mc_pending, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rstd_nostale", bus.writeEn, 0);

    // randomized traffic; WB stage holds its request while stalled
    cur_we = 0; cur_wd = '0; cur_wv = '0;
    for (int n = 0; n < 400; n++) begin
      if (!m_stall) begin
        cur_we = ($urandom_range(0, 99) < 60);
        cur_wd = 5'($urandom_range(0, 7));
        cur_wv = $urandom;
      end
      cyc(($urandom_range(0, 99) < 2), cur_we, cur_wd, cur_wv,
          ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
